// File: rtl/d_pipe_reg_if.sv
// Bus bundle for d_pipe_reg: control and data going into the delay line
// and the registered last-stage view coming out of it.
//
// Qualifier semantics: d_valid marks d as meaningful on any edge where
// en=1 and flush=0. There is no ready/backpressure path. The line always
// accepts, and whatever sits in the last stage is dropped on the next
// advance. q_valid qualifies q in the same way on the output side.
interface d_pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [OCC_W-1:0] occupancy;

  // Producer/consumer side that drives the line and observes its output.
  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, occupancy
  );

  // The delay line itself.
  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, occupancy
  );
endinterface

// File: rtl/d_pipe_reg.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid bits,
// global stall, synchronous flush and a registered occupancy count.
// With DEPTH=1, en=1 and flush=0 it behaves as a plain WIDTH-bit D register.
module d_pipe_reg #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 3,
  parameter logic [WIDTH-1:0] RST_VAL      = '0,
  parameter bit               GATE_INVALID = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  d_pipe_reg_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q   [DEPTH];
  logic [WIDTH-1:0] stage_nxt [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_nxt;
  logic [OCC_W-1:0] occ_q;

  // Next contents of each stage on an advance. With gating enabled, a stage
  // that receives valid=0 loads RST_VAL so bubbles carry a known value.
  always_comb begin
    vld_nxt      = '0;
    stage_nxt[0] = (GATE_INVALID && !bus.d_valid) ? RST_VAL : bus.d;
    vld_nxt[0]   = bus.d_valid;
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt[i]   = vld_q[i-1];
      stage_nxt[i] = (GATE_INVALID && !vld_q[i-1]) ? RST_VAL : stage_q[i-1];
    end
  end

  // State update: reset and flush clear everything, enable advances, else hold.
  // Occupancy moves by the valid entering minus the valid falling off the end,
  // so it always equals the popcount of vld_q without an adder tree.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_nxt[i];
      end
      vld_q <= vld_nxt;
      occ_q <= occ_q + OCC_W'(bus.d_valid) - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  assign bus.q         = stage_q[DEPTH-1];
  assign bus.q_valid   = vld_q[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule
